// File: rtl/mem_port_arbiter.sv
// Purpose : shares one external memory port between the core's fetch path and data path.
// Latency : request seen in cycle t -> MemEn in t+1 -> Valid in t+2 at the earliest.
// Backpr. : one transaction in flight; the other requester waits and sees Stall.
//
// Ports
//   clk, reset       clock and synchronous active-low reset
//   IReq/IAdr        fetch request, held until IValid; IRdata/IValid return the instruction
//   DReq/DWrite/...  data request (load or store), held until DValid; DRdata/DValid return
//   MemEn..MemWriteData  request side of the external port, held until MemGnt
//   MemGnt           memory accepts the presented request
//   MemRValid        memory response/ack, MemReadData carries load/fetch data
//   Stall            some request is still waiting for its completion pulse
//   FetchStallCnt, DataStallCnt  saturating stall-cycle counters
//
// Build option: define MEM_ARB_PERF_EN to add the two stall counters and their ports.
// Without it the counters and ports are absent and nothing else changes.

module mem_port_arbiter #(
  parameter int BIT_COUNT = 32,
  parameter int WORD_SIZE = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  // fetch requester
  input  logic                   IReq,
  input  logic [BIT_COUNT-1:0]   IAdr,
  output logic [WORD_SIZE-1:0]   IRdata,
  output logic                   IValid,
  // data requester
  input  logic                   DReq,
  input  logic                   DWrite,
  input  logic [WORD_SIZE/8-1:0] DByteEn,
  input  logic [BIT_COUNT-1:0]   DAdr,
  input  logic [WORD_SIZE-1:0]   DWdata,
  output logic [WORD_SIZE-1:0]   DRdata,
  output logic                   DValid,
  // external memory port
  output logic                   MemEn,
  output logic                   MemWrite,
  output logic [WORD_SIZE/8-1:0] ByteEn,
  output logic [BIT_COUNT-1:0]   MemAdr,
  output logic [WORD_SIZE-1:0]   MemWriteData,
  input  logic                   MemGnt,
  input  logic                   MemRValid,
  input  logic [WORD_SIZE-1:0]   MemReadData,
  // core stall
  output logic                   Stall
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]   FetchStallCnt,
  output logic [CNT_WIDTH-1:0]   DataStallCnt
`endif
);

  localparam int BE_W = WORD_SIZE / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t state;
  owner_t owner;
  owner_t last_owner;
  owner_t pick;

  // The latched request lives directly in the output registers. They are
  // loaded when a request is accepted in IDLE and cleared on MemGnt, so the
  // port reads all-zero whenever it is not presenting a request.
  logic                 mem_en_q;
  logic                 mem_write_q;
  logic [BE_W-1:0]      byte_en_q;
  logic [BIT_COUNT-1:0] mem_adr_q;
  logic [WORD_SIZE-1:0] mem_wdata_q;

  logic rsp_hit;

  // Single requester wins outright; on a tie the one that did not own the
  // port last time goes first.
  always_comb begin
    pick = OWN_FETCH;
    if (IReq && DReq) begin
      pick = (last_owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
    end else if (DReq) begin
      pick = OWN_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      owner       <= OWN_FETCH;
      last_owner  <= OWN_FETCH;
      mem_en_q    <= 1'b0;
      mem_write_q <= 1'b0;
      byte_en_q   <= '0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IReq || DReq) begin
            owner    <= pick;
            mem_en_q <= 1'b1;
            if (pick == OWN_DATA) begin
              mem_write_q <= DWrite;
              byte_en_q   <= DByteEn;
              mem_adr_q   <= DAdr;
              mem_wdata_q <= DWdata;
            end else begin
              // Fetches are always full-word reads.
              mem_write_q <= 1'b0;
              byte_en_q   <= '1;
              mem_adr_q   <= IAdr;
              mem_wdata_q <= '0;
            end
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (MemGnt) begin
            mem_en_q    <= 1'b0;
            mem_write_q <= 1'b0;
            byte_en_q   <= '0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            state       <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (MemRValid) begin
            last_owner <= owner;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A response only completes a transaction while waiting for one. It is
  // also masked during a reset cycle so an abandoned transaction never
  // produces a completion pulse.
  assign rsp_hit = reset && (state == S_WAIT) && MemRValid;

  assign IValid = rsp_hit && (owner == OWN_FETCH);
  assign DValid = rsp_hit && (owner == OWN_DATA);

  assign IRdata = MemReadData;
  assign DRdata = MemReadData;

  assign MemEn        = mem_en_q;
  assign MemWrite     = mem_write_q;
  assign ByteEn       = byte_en_q;
  assign MemAdr       = mem_adr_q;
  assign MemWriteData = mem_wdata_q;

  assign Stall = (IReq && !IValid) || (DReq && !DValid);

`ifdef MEM_ARB_PERF_EN
  logic [CNT_WIDTH-1:0] fetch_stall_q;
  logic [CNT_WIDTH-1:0] data_stall_q;

  // Counters stick at all ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_stall_q <= '0;
      data_stall_q  <= '0;
    end else begin
      if (IReq && !IValid && (fetch_stall_q != '1)) begin
        fetch_stall_q <= fetch_stall_q + CNT_WIDTH'(1);
      end
      if (DReq && !DValid && (data_stall_q != '1)) begin
        data_stall_q <= data_stall_q + CNT_WIDTH'(1);
      end
    end
  end

  assign FetchStallCnt = fetch_stall_q;
  assign DataStallCnt  = data_stall_q;
`endif

endmodule
